// File: rtl/sound_square_ch.sv
// Square-wave sound channel: duty oscillator, length counter and volume envelope; level is registered (1 cycle).
// Define SOUND_SWEEP_EN to add the frequency sweep unit (NRx0); without it NRx0 and tick_sweep are ignored.
module sound_square_ch #(
    parameter logic [15:0] BASE_ADDR = 16'hFF10,
    parameter int          FREQ_W    = 11,
    parameter int          LEN_W     = 6,
    parameter int          VOL_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      a,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    input  logic             rd,
    input  logic             wr,
    input  logic             ce_freq,
    input  logic             tick_len,
    input  logic             tick_env,
    input  logic             tick_sweep,
    output logic [VOL_W-1:0] level,
    output logic             active
);

    localparam logic [FREQ_W:0] FREQ_FULL = {1'b1, {FREQ_W{1'b0}}};
    localparam logic [LEN_W:0]  LEN_FULL  = {1'b1, {LEN_W{1'b0}}};

    logic [15:0] off;
    logic        in_rng;
    logic        wr1, wr2, wr3, wr4, trig, dac_on;

    logic [1:0]        duty_q,   duty_d;
    logic [7:0]        nr2_q,    nr2_d;
    logic [FREQ_W-1:0] freq_q,   freq_d;
    logic              len_en_q, len_en_d;
    logic [FREQ_W:0]   ftmr_q,   ftmr_d;
    logic [2:0]        step_q,   step_d;
    logic [LEN_W:0]    len_q,    len_d;
    logic [3:0]        vol_q,    vol_d;
    logic [2:0]        env_q,    env_d;
    logic              active_q, active_d;
    logic [VOL_W-1:0]  level_q,  level_d;
    logic [7:0]        pat;
    logic              duty_bit;
    logic              unused_ok;

`ifdef SOUND_SWEEP_EN
    logic              wr0;
    logic [6:0]        nr0_q,    nr0_d;
    logic [FREQ_W-1:0] shadow_q, shadow_d;
    logic [2:0]        swt_q,    swt_d;
    logic [FREQ_W-1:0] sw_src;
    logic [FREQ_W:0]   sw_new;
    assign wr0 = wr && in_rng && (off[2:0] == 3'd0);
`endif

    assign off       = a - BASE_ADDR;
    assign in_rng    = off < 16'd5;
    assign wr1       = wr && in_rng && (off[2:0] == 3'd1);
    assign wr2       = wr && in_rng && (off[2:0] == 3'd2);
    assign wr3       = wr && in_rng && (off[2:0] == 3'd3);
    assign wr4       = wr && in_rng && (off[2:0] == 3'd4);
    assign trig      = wr4 && din[7];
    assign dac_on    = nr2_q[7:3] != 5'd0;
    assign level     = level_q;
    assign active    = active_q;
    assign unused_ok = ^{din, tick_sweep};

    always_comb begin
        dout = 8'hFF;
        if (rd && in_rng) begin
            case (off[2:0])
`ifdef SOUND_SWEEP_EN
                3'd0:    dout = {1'b1, nr0_q};
`endif
                3'd1:    dout = {duty_q, 6'h3F};
                3'd2:    dout = nr2_q;
                3'd4:    dout = {1'b1, len_en_q, 6'h3F};
                default: dout = 8'hFF;
            endcase
        end
    end

    // Patterns are written step 0 first (MSB) to step 7 (LSB).
    always_comb begin
        case (duty_q)
            2'b00:   pat = 8'b0000_0001;
            2'b01:   pat = 8'b1000_0001;
            2'b10:   pat = 8'b1000_0111;
            default: pat = 8'b0111_1110;
        endcase
        duty_bit = pat[3'd7 - step_q];
        level_d  = (active_q && duty_bit) ? (VOL_W'(vol_q) << (VOL_W - 4)) : '0;
    end

    always_comb begin
        duty_d   = duty_q;
        nr2_d    = nr2_q;
        freq_d   = freq_q;
        len_en_d = len_en_q;
        ftmr_d   = ftmr_q;
        step_d   = step_q;
        len_d    = len_q;
        vol_d    = vol_q;
        env_d    = env_q;
        active_d = active_q;

        if (wr2) begin
            nr2_d = din;
            if (din[7:3] == 5'd0) active_d = 1'b0;
        end
        if (wr3) freq_d[7:0] = din;
        if (wr4) begin
            freq_d[FREQ_W-1:8] = din[FREQ_W-9:0];
            len_en_d           = din[6];
        end
        if (trig) active_d = dac_on;

        if (wr1) begin
            duty_d = din[7:6];
            len_d  = LEN_FULL - {1'b0, din[LEN_W-1:0]};
        end else if (trig) begin
            if (len_q == '0) len_d = LEN_FULL;
        end else if (tick_len && len_en_q && len_q != '0) begin
            len_d = len_q - (LEN_W+1)'(1);
            if (len_q == (LEN_W+1)'(1)) active_d = 1'b0;
        end

        // A step fires on the pulse that would take the timer to zero, so each step lasts exactly the reload value.
        if (trig) begin
            ftmr_d = FREQ_FULL - {1'b0, freq_d};
        end else if (ce_freq) begin
            if (ftmr_q <= (FREQ_W+1)'(1)) begin
                ftmr_d = FREQ_FULL - {1'b0, freq_q};
                step_d = step_q + 3'd1;
            end else begin
                ftmr_d = ftmr_q - (FREQ_W+1)'(1);
            end
        end

        if (trig) begin
            vol_d = nr2_q[7:4];
            env_d = nr2_q[2:0];
        end else if (tick_env && nr2_q[2:0] != 3'd0) begin
            if (env_q <= 3'd1) begin
                env_d = nr2_q[2:0];
                if (nr2_q[3]) begin
                    if (vol_q != 4'hF) vol_d = vol_q + 4'd1;
                end else if (vol_q != 4'h0) begin
                    vol_d = vol_q - 4'd1;
                end
            end else begin
                env_d = env_q - 3'd1;
            end
        end

`ifdef SOUND_SWEEP_EN
        nr0_d    = nr0_q;
        shadow_d = shadow_q;
        swt_d    = swt_q;
        if (wr0) nr0_d = din[6:0];
        sw_src = trig ? freq_d : shadow_q;
        sw_new = nr0_q[3] ? ({1'b0, sw_src} - {1'b0, sw_src >> nr0_q[2:0]})
                          : ({1'b0, sw_src} + {1'b0, sw_src >> nr0_q[2:0]});
        if (trig) begin
            shadow_d = freq_d;
            swt_d    = nr0_q[6:4];
            if (nr0_q[2:0] != 3'd0 && sw_new[FREQ_W]) active_d = 1'b0;
        end else if (tick_sweep && !wr3 && !wr4 && nr0_q[6:4] != 3'd0) begin
            if (swt_q <= 3'd1) begin
                swt_d = nr0_q[6:4];
                if (nr0_q[2:0] != 3'd0) begin
                    if (sw_new[FREQ_W]) begin
                        active_d = 1'b0;
                    end else begin
                        freq_d   = sw_new[FREQ_W-1:0];
                        shadow_d = sw_new[FREQ_W-1:0];
                    end
                end
            end else begin
                swt_d = swt_q - 3'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q   <= '0;
            nr2_q    <= '0;
            freq_q   <= '0;
            len_en_q <= 1'b0;
            ftmr_q   <= '0;
            step_q   <= '0;
            len_q    <= '0;
            vol_q    <= '0;
            env_q    <= '0;
            active_q <= 1'b0;
            level_q  <= '0;
`ifdef SOUND_SWEEP_EN
            nr0_q    <= '0;
            shadow_q <= '0;
            swt_q    <= '0;
`endif
        end else begin
            duty_q   <= duty_d;
            nr2_q    <= nr2_d;
            freq_q   <= freq_d;
            len_en_q <= len_en_d;
            ftmr_q   <= ftmr_d;
            step_q   <= step_d;
            len_q    <= len_d;
            vol_q    <= vol_d;
            env_q    <= env_d;
            active_q <= active_d;
            level_q  <= level_d;
`ifdef SOUND_SWEEP_EN
            nr0_q    <= nr0_d;
            shadow_q <= shadow_d;
            swt_q    <= swt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sound_square_ch.sv
// Directed + randomized bench for sound_square_ch (default build), checked against an arithmetic reference model.
module tb_sound_square_ch;

    localparam logic [15:0] BASE = 16'hFF10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  din, dout;
    logic        rd, wr, ce_freq, tick_len, tick_env, tick_sweep;
    logic [3:0]  level;
    logic        active;

    int n_cmp = 0;
    int n_bad = 0;

    // Duty waveforms as listed, character k is step k.
    string pat [4] = '{"00000001", "10000001", "10000111", "01111110"};
    // Reference oscillator: step = (step at last trigger + pulses since trigger / period) mod 8.
    int m_base, m_p, m_n;

    sound_square_ch dut (
        .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout), .rd(rd), .wr(wr),
        .ce_freq(ce_freq), .tick_len(tick_len), .tick_env(tick_env), .tick_sweep(tick_sweep),
        .level(level), .active(active)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic wreg(input int idx, input logic [7:0] d);
        a = BASE + 16'(idx); din = d; wr = 1'b1;
        tick1();
        wr = 1'b0;
    endtask

    task automatic rreg(input int idx, output logic [7:0] d);
        a = BASE + 16'(idx); rd = 1'b1;
        #1 d = dout;
        rd = 1'b0;
        #1;
    endtask

    task automatic fpulses(input int n);
        ce_freq = 1'b1;
        repeat (n) tick1();
        ce_freq = 1'b0;
        tick1();
        m_p += n;
    endtask

    task automatic eticks(input int n);
        tick_env = 1'b1;
        repeat (n) tick1();
        tick_env = 1'b0;
        tick1();
    endtask

    task automatic lticks(input int n);
        tick_len = 1'b1;
        repeat (n) tick1();
        tick_len = 1'b0;
        tick1();
    endtask

    function automatic int m_step();
        return (m_base + m_p / m_n) % 8;
    endfunction

    function automatic int m_level(input int duty, input int vol);
        byte c;
        c = pat[duty][m_step()];
        return (c == "1") ? vol : 0;
    endfunction

    task automatic m_trigger(input int f);
        m_base = m_step();
        m_p    = 0;
        m_n    = 2048 - f;
    endtask

    initial begin
        logic [7:0]  r;
        logic [10:0] fr;
        int highs, duty, vol, per, dir, t, n, want, len;

        rst = 1'b1; a = '0; din = '0; rd = 1'b0; wr = 1'b0;
        ce_freq = 1'b0; tick_len = 1'b0; tick_env = 1'b0; tick_sweep = 1'b0;
        m_base = 0; m_p = 0; m_n = 1;
        repeat (2) tick1();
        check("rst_active", active, 0);
        check("rst_level", level, 0);
        rst = 1'b0;
        tick1();
        rreg(0, r);  check("rst_rd_nr0", r, 8'hFF);
        rreg(1, r);  check("rst_rd_nr1", r, 8'h3F);
        rreg(2, r);  check("rst_rd_nr2", r, 8'h00);
        rreg(3, r);  check("rst_rd_nr3", r, 8'hFF);
        rreg(4, r);  check("rst_rd_nr4", r, 8'hBF);
        rreg(5, r);  check("rd_above", r, 8'hFF);
        rreg(-1, r); check("rd_below", r, 8'hFF);

        // Basic note: duty 10, freq 0x783 -> 125 pulses per step.
        wreg(2, 8'hF3); wreg(1, 8'h80); wreg(3, 8'h83); wreg(4, 8'h87);
        m_trigger(12'h783);
        tick1();
        check("note_active", active, 1);
        rreg(1, r); check("rd_nr1", r, 8'hBF);
        rreg(2, r); check("rd_nr2", r, 8'hF3);
        rreg(4, r); check("rd_nr4", r, 8'hBF);
        a = BASE + 16'd2; #1 check("rd_idle", dout, 8'hFF);
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            check("duty10_step", level, m_level(2, 15));
            if (level == 4'd15) highs++;
            fpulses(124);
            check("duty10_hold", level, m_level(2, 15));
            fpulses(1);
        end
        check("duty10_highs", highs, 4);

        // Length counter.
        wreg(1, 8'hBF); wreg(4, 8'hC7); m_trigger(12'h783);
        check("len1_pre", active, 1);
        lticks(1);
        check("len1_post", active, 0);
        wreg(4, 8'hC7); m_trigger(12'h783);
        check("len64_trig", active, 1);
        lticks(63);
        check("len64_63", active, 1);
        lticks(1);
        check("len64_64", active, 0);
        wreg(1, 8'hBE); wreg(4, 8'hC7); m_trigger(12'h783);
        a = BASE + 16'd1; din = 8'hBE; wr = 1'b1; tick_len = 1'b1;
        tick1();
        wr = 1'b0; tick_len = 1'b0;
        lticks(1);
        check("len_wr_prio", active, 1);
        lticks(1);
        check("len_wr_prio_end", active, 0);
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(50, 63);
            t   = $urandom_range(0, 64 - len + 1);
            wreg(1, 8'h80 | 8'(len)); wreg(4, 8'hC7); m_trigger(12'h783);
            lticks(t);
            check("len_rand", active, (t < 64 - len) ? 1 : 0);
        end
        wreg(1, 8'hBE); wreg(4, 8'h87); m_trigger(12'h783);
        lticks(5);
        check("len_disabled", active, 1);

        // DAC off behaviour.
        wreg(2, 8'h08); wreg(4, 8'h80); m_trigger(12'h083);
        tick1();
        check("dac_vol0_active", active, 1);
        check("dac_vol0_level", level, 0);
        wreg(2, 8'h00);
        check("dac_off_clear", active, 0);
        wreg(4, 8'h80); m_trigger(12'h083);
        tick1();
        check("dac_off_trig", active, 0);

        // Envelope: pick a duty whose bit is 1 at the current step so level shows volume.
        duty = (m_step() >= 1 && m_step() <= 6) ? 3 : 2;
        wreg(1, 8'(duty << 6));
        wreg(2, 8'hF1);
        tick_env = 1'b1;
        wreg(4, 8'h80);
        tick_env = 1'b0;
        m_trigger(12'h080);
        tick1();
        check("env_trig_prio", level, 15);
        for (int i = 0; i < 18; i++) begin
            check("env_down", level, (15 - i > 0) ? 15 - i : 0);
            eticks(1);
        end
        for (int it = 0; it < 4; it++) begin
            vol = $urandom_range(1, 15);
            per = $urandom_range(1, 7);
            dir = $urandom_range(0, 1);
            wreg(2, 8'((vol << 4) | (dir << 3) | per));
            wreg(4, 8'h80); m_trigger(12'h080);
            tick1();
            t = 0;
            for (int j = 0; j < 5; j++) begin
                n = $urandom_range(0, 6);
                eticks(n);
                t += n;
                want = dir ? vol + t / per : vol - t / per;
                if (want > 15) want = 15;
                if (want < 0) want = 0;
                check("env_rand", level, want);
            end
        end

        // Randomized waveform: short periods, random duty/volume, random pulse bursts.
        for (int it = 0; it < 4; it++) begin
            duty = $urandom_range(0, 3);
            per  = $urandom_range(1, 6);
            vol  = $urandom_range(1, 15);
            fr   = 11'(2048 - per);
            wreg(1, 8'(duty << 6)); wreg(2, 8'(vol << 4));
            wreg(3, fr[7:0]); wreg(4, 8'h80 | 8'(fr[10:8]));
            m_trigger(int'(fr));
            tick1();
            for (int j = 0; j < 8; j++) begin
                fpulses($urandom_range(0, 9));
                repeat ($urandom_range(0, 2)) tick1();
                check("wave_rand", level, m_level(duty, vol));
            end
        end

        // Reset in the middle of a note.
        wreg(1, 8'hC0); wreg(2, 8'hF0); wreg(4, 8'h87);
        rst = 1'b1;
        #1;
        check("midrst_active", active, 0);
        check("midrst_level", level, 0);
        rreg(1, r); check("midrst_rd_nr1", r, 8'h3F);
        rreg(2, r); check("midrst_rd_nr2", r, 8'h00);
        rreg(4, r); check("midrst_rd_nr4", r, 8'hBF);
        tick1();
        rst = 1'b0;
        m_base = 0; m_p = 0; m_n = 1;
        eticks(3); lticks(3);
        check("postrst_active", active, 0);
        check("postrst_level", level, 0);

        // Frequency change applies only at the next reload (duty 01: steps 0 and 7 high).
        wreg(2, 8'hF0); wreg(1, 8'h40); wreg(3, 8'hF6); wreg(4, 8'h87);
        tick1();
        check("fchg_start", level, 15);
        fpulses(5);
        check("fchg_5", level, 15);
        wreg(3, 8'hFC);
        fpulses(4);
        check("fchg_old_hold", level, 15);
        fpulses(1);
        check("fchg_old_edge", level, 0);
        fpulses(23);
        check("fchg_new_hold", level, 0);
        fpulses(1);
        check("fchg_new_edge", level, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
